// File: rtl/calc_pkg.sv
// Shared constants for the calculator controller: op codes, FSM encoding, data width.
package calc_pkg;

    localparam int DATA_W = 40;

    localparam logic [1:0] OP_ADD      = 2'b00;
    localparam logic [1:0] OP_MINUS    = 2'b01;
    localparam logic [1:0] OP_MULTIPLE = 2'b10;
    localparam logic [1:0] OP_DIVIDE   = 2'b11;

    localparam logic [DATA_W-1:0] DISP_MAX_POS = 40'd999999;
    localparam logic [DATA_W-1:0] DISP_MAX_NEG = 40'd99999;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENTER_A,
        ST_OP_SEL,
        ST_ENTER_B,
        ST_EXEC,
        ST_WAIT,
        ST_SHOW,
        ST_ERROR
    } state_t;

endpackage

// File: rtl/calc_digit_acc.sv
// One decimal operand accumulator: start with a digit, load a value, append digits up to MAX_DIGITS.
module calc_digit_acc
    import calc_pkg::*;
#(
    parameter int MAX_DIGITS = 6
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_load,
    input  logic              i_append,
    input  logic [3:0]        i_digit,
    input  logic [DATA_W-1:0] i_load_val,
    output logic [DATA_W-1:0] o_value
);

    localparam int CW = $clog2(MAX_DIGITS + 1);

    logic [DATA_W-1:0] r_value;
    logic [CW-1:0]     r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_value <= '0;
            r_count <= '0;
        end else if (i_start) begin
            r_value <= DATA_W'(i_digit);
            r_count <= CW'(1);
        end else if (i_load) begin
            // A loaded result counts as a full operand so no digits can be appended to it.
            r_value <= i_load_val;
            r_count <= CW'(MAX_DIGITS);
        end else if (i_append && (r_count < CW'(MAX_DIGITS))) begin
            r_value <= (r_value * DATA_W'(10)) + DATA_W'(i_digit);
            r_count <= r_count + CW'(1);
        end
    end

    assign o_value = r_value;

endmodule

// File: rtl/calc_ctrl.sv
// Calculator key-entry controller driving an external arithmetic unit.
// Define CALC_CTRL_CHAIN_EN to let an operator key in SHOW chain on the displayed result.
module calc_ctrl
    import calc_pkg::*;
#(
    parameter int MAX_DIGITS  = 6,
    parameter int RESULT_WAIT = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_digit_valid,
    input  logic [3:0]        i_digit,
    input  logic              i_op_valid,
    input  logic [1:0]        i_op,
    input  logic              i_equal,
    input  logic              i_clear,
    input  logic [DATA_W-1:0] i_result,
    input  logic              i_err,
    input  logic              i_res_sign,
    output logic [DATA_W-1:0] o_s1,
    output logic [DATA_W-1:0] o_s2,
    output logic [1:0]        o_arith_func,
    output logic              o_sign,
    output logic              o_en,
    output logic [DATA_W-1:0] o_display,
    output logic              o_disp_sign,
    output logic              o_err,
    output logic              o_busy
);

`ifdef CALC_CTRL_CHAIN_EN
    localparam bit CHAIN_EN = 1'b1;
`else
    localparam bit CHAIN_EN = 1'b0;
`endif

    state_t            r_state, w_state_next;
    logic [3:0]        r_wait_cnt;
    logic [1:0]        r_func;
    logic [DATA_W-1:0] r_result;
    logic              r_res_sign;
    logic              w_clr, w_key_eq, w_key_op, w_key_dig;
    logic              w_a_start, w_a_load, w_a_append, w_b_start, w_b_append;
    logic              w_func_we, w_latch_res, w_en, w_sign, w_reject, w_wait_done;
    logic [DATA_W-1:0] w_a_value, w_b_value;

    // Clear behaves exactly like reset; key priority is equal > op > digit.
    assign w_clr       = i_reset | i_clear;
    assign w_key_eq    = i_equal;
    assign w_key_op    = i_op_valid & ~i_equal;
    assign w_key_dig   = i_digit_valid & (i_digit <= 4'd9) & ~i_equal & ~i_op_valid;
    assign w_wait_done = (r_wait_cnt == 4'(RESULT_WAIT - 1));
    assign w_reject    = ((r_func == OP_DIVIDE) && (w_b_value == '0)) ||
                         (w_sign && (r_func != OP_MINUS));

    calc_digit_acc #(.MAX_DIGITS(MAX_DIGITS)) u_acc_a (
        .i_clk      (i_clk),
        .i_reset    (w_clr),
        .i_start    (w_a_start),
        .i_load     (w_a_load),
        .i_append   (w_a_append),
        .i_digit    (i_digit),
        .i_load_val (r_result),
        .o_value    (w_a_value)
    );

    calc_digit_acc #(.MAX_DIGITS(MAX_DIGITS)) u_acc_b (
        .i_clk      (i_clk),
        .i_reset    (w_clr),
        .i_start    (w_b_start),
        .i_load     (1'b0),
        .i_append   (w_b_append),
        .i_digit    (i_digit),
        .i_load_val ('0),
        .o_value    (w_b_value)
    );

`ifdef CALC_CTRL_CHAIN_EN
    logic r_sign;
    always_ff @(posedge i_clk) begin
        if (w_clr)
            r_sign <= 1'b0;
        else if (w_a_load)
            r_sign <= r_res_sign;
        else if (w_a_start)
            r_sign <= 1'b0;
    end
    assign w_sign = r_sign;
`else
    assign w_sign = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (w_clr) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
            r_func     <= OP_ADD;
            r_result   <= '0;
            r_res_sign <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= (r_state == ST_WAIT) ? r_wait_cnt + 4'd1 : 4'd0;
            if (w_func_we)
                r_func <= i_op;
            if (w_latch_res) begin
                r_result   <= i_result;
                r_res_sign <= i_res_sign;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_a_start    = 1'b0;
        w_a_load     = 1'b0;
        w_a_append   = 1'b0;
        w_b_start    = 1'b0;
        w_b_append   = 1'b0;
        w_func_we    = 1'b0;
        w_latch_res  = 1'b0;
        w_en         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_key_op) begin
                    w_func_we    = 1'b1;
                    w_state_next = ST_OP_SEL;
                end else if (w_key_dig) begin
                    w_a_start    = 1'b1;
                    w_state_next = ST_ENTER_A;
                end
            end
            ST_ENTER_A: begin
                if (w_key_op) begin
                    w_func_we    = 1'b1;
                    w_state_next = ST_OP_SEL;
                end else if (w_key_dig) begin
                    w_a_append = 1'b1;
                end
            end
            ST_OP_SEL: begin
                if (w_key_op) begin
                    w_func_we = 1'b1;
                end else if (w_key_dig) begin
                    w_b_start    = 1'b1;
                    w_state_next = ST_ENTER_B;
                end
            end
            ST_ENTER_B: begin
                if (w_key_eq)
                    w_state_next = ST_EXEC;
                else if (w_key_dig)
                    w_b_append = 1'b1;
            end
            ST_EXEC: begin
                if (w_reject) begin
                    w_state_next = ST_ERROR;
                end else begin
                    w_en         = 1'b1;
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_wait_done) begin
                    if (i_err) begin
                        w_state_next = ST_ERROR;
                    end else begin
                        w_latch_res  = 1'b1;
                        w_state_next = ST_SHOW;
                    end
                end
            end
            ST_SHOW: begin
                if (w_key_op && CHAIN_EN) begin
                    w_a_load     = 1'b1;
                    w_func_we    = 1'b1;
                    w_state_next = ST_OP_SEL;
                end else if (w_key_dig) begin
                    w_a_start    = 1'b1;
                    w_state_next = ST_ENTER_A;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        o_display   = '0;
        o_disp_sign = 1'b0;
        case (r_state)
            ST_IDLE, ST_ENTER_A, ST_OP_SEL: begin
                o_display   = w_a_value;
                o_disp_sign = w_sign;
            end
            ST_ENTER_B, ST_EXEC, ST_WAIT: o_display = w_b_value;
            ST_SHOW: begin
                o_display   = r_result;
                o_disp_sign = r_res_sign;
            end
            default: ;
        endcase
    end

    assign o_s1         = w_a_value;
    assign o_s2         = w_b_value;
    assign o_arith_func = r_func;
    assign o_sign       = w_sign;
    assign o_en         = w_en;
    assign o_busy       = (r_state == ST_EXEC) || (r_state == ST_WAIT);
    assign o_err        = (r_state == ST_ERROR);

endmodule
